// File: rtl/bestmove_formatter.sv
// rtl/bestmove_formatter.sv - serialises a captured move as a UCI "bestmove" text line, one byte per handshake
module bestmove_formatter #(
  parameter bit EOL_CRLF = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [5:0] from_sq_in,
  input  logic [5:0] to_sq_in,
  input  logic [2:0] promo_in,
  input  logic       move_valid_in,
  output logic       ready_out,
  output logic [7:0] char_out,
  output logic       char_out_valid,
  input  logic       char_out_ready,
  output logic       done_out,
  output logic       overflow_out
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic       done_q, done_d;
  logic       ovf_q, ovf_d;
  logic [5:0] from_q, to_q;
  logic [2:0] promo_q;

  logic       null_mv;
  logic       has_promo;
  logic       accept;
  logic [3:0] idx_nxt;
  logic [7:0] char_c;

  assign null_mv   = (from_q == to_q);
  assign has_promo = !null_mv && (promo_q >= 3'd1) && (promo_q <= 3'd4);
  assign accept    = move_valid_in && (state_q == IDLE);

  // Line positions are fixed: 0-8 header, 9-12 squares, 13 promo, 14 CR, 15 LF.
  // Absent positions are skipped so no bubble appears on the stream.
  always_comb begin
    idx_nxt = idx_q + 4'd1;
    if (idx_nxt == 4'd13 && !has_promo) idx_nxt = 4'd14;
    if (idx_nxt == 4'd14 && !EOL_CRLF)  idx_nxt = 4'd15;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (move_valid_in && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (move_valid_in) begin
          state_d = SEND;
          idx_d   = 4'd0;
        end
      end
      SEND: begin
        if (char_out_ready) begin
          if (idx_q == 4'd15) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      from_q  <= 6'd0;
      to_q    <= 6'd0;
      promo_q <= 3'd0;
    end else if (accept) begin
      from_q  <= from_sq_in;
      to_q    <= to_sq_in;
      promo_q <= promo_in;
    end
  end

  always_comb begin
    char_c = 8'h00;
    case (idx_q)
      4'd0:  char_c = 8'h62;
      4'd1:  char_c = 8'h65;
      4'd2:  char_c = 8'h73;
      4'd3:  char_c = 8'h74;
      4'd4:  char_c = 8'h6D;
      4'd5:  char_c = 8'h6F;
      4'd6:  char_c = 8'h76;
      4'd7:  char_c = 8'h65;
      4'd8:  char_c = 8'h20;
      4'd9:  char_c = null_mv ? 8'h30 : 8'h61 + {5'd0, from_q[2:0]};
      4'd10: char_c = null_mv ? 8'h30 : 8'h31 + {5'd0, from_q[5:3]};
      4'd11: char_c = null_mv ? 8'h30 : 8'h61 + {5'd0, to_q[2:0]};
      4'd12: char_c = null_mv ? 8'h30 : 8'h31 + {5'd0, to_q[5:3]};
      4'd13: begin
        case (promo_q)
          3'd1:    char_c = 8'h6E;
          3'd2:    char_c = 8'h62;
          3'd3:    char_c = 8'h72;
          3'd4:    char_c = 8'h71;
          default: char_c = 8'h00;
        endcase
      end
      4'd14: char_c = 8'h0D;
      4'd15: char_c = 8'h0A;
      default: char_c = 8'h00;
    endcase
  end

  assign ready_out      = (state_q == IDLE);
  assign char_out_valid = (state_q == SEND);
  assign char_out       = (state_q == SEND) ? char_c : 8'h00;
  assign done_out       = done_q;
  assign overflow_out   = ovf_q;

endmodule

// File: tb/tb_bestmove_formatter.sv
// tb/tb_bestmove_formatter.sv - scoreboard bench driving LF and CRLF formatter instances in lockstep
module tb_bestmove_formatter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] from_sq, to_sq;
  logic [2:0] promo;
  logic       mv;
  logic       rdy;
  logic       r0, v0, d0, o0;
  logic       r1, v1, d1, o1;
  logic [7:0] c0, c1;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt[2];
  logic       held[2];
  logic [7:0] held_c[2];
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  bestmove_formatter #(.EOL_CRLF(1'b0)) dut_lf (
    .clk_in(clk), .rst_n_in(rst_n), .from_sq_in(from_sq), .to_sq_in(to_sq),
    .promo_in(promo), .move_valid_in(mv), .ready_out(r0), .char_out(c0),
    .char_out_valid(v0), .char_out_ready(rdy), .done_out(d0), .overflow_out(o0));

  bestmove_formatter #(.EOL_CRLF(1'b1)) dut_cr (
    .clk_in(clk), .rst_n_in(rst_n), .from_sq_in(from_sq), .to_sq_in(to_sq),
    .promo_in(promo), .move_valid_in(mv), .ready_out(r1), .char_out(c1),
    .char_out_valid(v1), .char_out_ready(rdy), .done_out(d1), .overflow_out(o1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [5:0] f, input logic [5:0] t, input logic [2:0] p);
    logic [7:0] s[$];
    string hdr;
    hdr = "bestmove ";
    for (int i = 0; i < 9; i++) s.push_back(hdr[i]);
    if (f == t) begin
      for (int i = 0; i < 4; i++) s.push_back(8'h30);
    end else begin
      s.push_back(8'h61 + {5'd0, f[2:0]});
      s.push_back(8'h31 + {5'd0, f[5:3]});
      s.push_back(8'h61 + {5'd0, t[2:0]});
      s.push_back(8'h31 + {5'd0, t[5:3]});
      case (p)
        3'd1: s.push_back(8'h6E);
        3'd2: s.push_back(8'h62);
        3'd3: s.push_back(8'h72);
        3'd4: s.push_back(8'h71);
        default: ;
      endcase
    end
    foreach (s[i]) begin
      q0.push_back(s[i]);
      q1.push_back(s[i]);
    end
    q0.push_back(8'h0A);
    q1.push_back(8'h0D);
    q1.push_back(8'h0A);
  endtask

  task automatic mon(input int id, input logic v, input logic ro, input logic d, input logic [7:0] c);
    logic [7:0] e;
    int sz;
    if (held[id]) begin
      check($sformatf("hold_valid%0d", id), {31'd0, v}, 32'd1);
      check($sformatf("hold_char%0d", id), {24'd0, c}, {24'd0, held_c[id]});
    end
    if (v && rdy) begin
      sz = (id == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        check($sformatf("extra_char%0d", id), {24'd0, c}, 32'hFFFF_FFFF);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("char%0d", id), {24'd0, c}, {24'd0, e});
      end
      hs_cnt[id]++;
      held[id] = 1'b0;
    end else if (v) begin
      held[id]   = 1'b1;
      held_c[id] = c;
    end else begin
      held[id] = 1'b0;
    end
    if (d) begin
      check($sformatf("ready_at_done%0d", id), {31'd0, ro}, 32'd1);
      sz = (id == 0) ? q0.size() : q1.size();
      check($sformatf("drained_at_done%0d", id), sz, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      mon(0, v0, r0, d0, c0);
      mon(1, v1, r1, d1, c1);
    end
  end

  task automatic drive_move(input logic [5:0] f, input logic [5:0] t, input logic [2:0] p);
    from_sq = f;
    to_sq   = t;
    promo   = p;
    mv      = 1'b1;
    push_line(f, t, p);
  endtask

  // Called #1 after the accept edge; exp_dX <= 0 skips the exact done-cycle check.
  task automatic finish_line(input bit rnd, input int exp_d0, input int exp_d1, input bit inject);
    int k0, k1;
    k0 = 0;
    k1 = 0;
    mv = 1'b0;
    from_sq = 6'($urandom);
    to_sq   = 6'($urandom);
    promo   = 3'($urandom);
    rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int k = 1; k <= 400 && (k0 == 0 || k1 == 0); k++) begin
      @(negedge clk);
      if (k == 1) check("first_valid", {30'd0, v0, v1}, 32'd3);
      if (d0 && k0 == 0) k0 = k;
      if (d1 && k1 == 0) k1 = k;
      @(posedge clk);
      #1;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mv  = (inject && k == 3);
    end
    mv = 1'b0;
    if (k0 == 0 || k1 == 0) check("done_timeout", {30'd0, k0 != 0, k1 != 0}, 32'd3);
    if (exp_d0 > 0) check("done_cycle_lf", k0, exp_d0);
    if (exp_d1 > 0) check("done_cycle_crlf", k1, exp_d1);
    @(negedge clk);
    check("done_one_cycle", {30'd0, d0, d1}, 32'd0);
    check("idle_ready", {30'd0, r0, r1}, 32'd3);
  endtask

  task automatic run_line(input logic [5:0] f, input logic [5:0] t, input logic [2:0] p,
                          input bit rnd, input int exp_d0, input int exp_d1, input bit inject);
    @(posedge clk);
    #1;
    drive_move(f, t, p);
    @(posedge clk);
    #1;
    finish_line(rnd, exp_d0, exp_d1, inject);
  endtask

  initial begin
    rst_n = 1'b0;
    from_sq = 6'd0;
    to_sq = 6'd0;
    promo = 3'd0;
    mv = 1'b0;
    rdy = 1'b1;
    hs_cnt[0] = 0;
    hs_cnt[1] = 0;
    held[0] = 1'b0;
    held[1] = 1'b0;
    held_c[0] = 8'h00;
    held_c[1] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", {30'd0, r0, r1}, 32'd3);
    check("rst_valid", {30'd0, v0, v1}, 32'd0);
    check("rst_char", {16'd0, c0, c1}, 32'd0);
    check("rst_done_ovf", {28'd0, d0, d1, o0, o1}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_line(6'd12, 6'd28, 3'd0, 1'b0, 15, 16, 1'b0);
    run_line(6'd52, 6'd60, 3'd4, 1'b0, 16, 17, 1'b0);
    run_line(6'd0, 6'd0, 3'd3, 1'b0, 15, 16, 1'b0);
    run_line(6'd6, 6'd21, 3'd0, 1'b1, 0, 0, 1'b0);
    run_line(6'd49, 6'd57, 3'd1, 1'b1, 0, 0, 1'b0);
    run_line(6'd63, 6'd63, 3'd7, 1'b1, 0, 0, 1'b0);
    check("ovf_clear", {30'd0, o0, o1}, 32'd0);

    run_line(6'd11, 6'd27, 3'd6, 1'b0, 15, 16, 1'b1);
    check("ovf_set", {30'd0, o0, o1}, 32'd3);
    run_line(6'd55, 6'd63, 3'd2, 1'b0, 16, 17, 1'b0);
    check("ovf_sticky", {30'd0, o0, o1}, 32'd3);

    hs_cnt[0] = 0;
    @(posedge clk);
    #1;
    drive_move(6'd8, 6'd16, 3'd0);
    @(posedge clk);
    #1;
    mv = 1'b0;
    rdy = 1'b1;
    for (int k = 0; k < 100 && hs_cnt[0] < 5; k++) @(posedge clk);
    check("five_chars_sent", hs_cnt[0], 5);
    #2;
    check("mid_line_valid", {30'd0, v0, v1}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", {30'd0, r0, r1}, 32'd3);
    check("async_rst_valid", {30'd0, v0, v1}, 32'd0);
    check("async_rst_char", {16'd0, c0, c1}, 32'd0);
    check("async_rst_done_ovf", {28'd0, d0, d1, o0, o1}, 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    drive_move(6'd1, 6'd10, 3'd0);
    @(posedge clk);
    #1;
    finish_line(1'b0, 15, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
